// File: rtl/reset_sequencer_pkg.sv
// Shared types and parameter helpers for the staged reset sequencer.
// Holds the FSM state encoding, the counter-width function and legal parameter ranges.
package reset_pkg;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 8;
    localparam int N_OUT_MIN       = 1;
    localparam int N_OUT_MAX       = 32;
    localparam int STRETCH_MIN     = 1;
    localparam int STAGGER_MIN     = 1;
    localparam int CNT_W_MIN       = 1;

    typedef enum logic [1:0] {
        HOLD    = 2'd0,
        RELEASE = 2'd1,
        RUN     = 2'd2
    } seq_state_t;

    // The shared stretch/stagger counter only ever reaches max(STRETCH, STAGGER) - 1.
    function automatic int cnt_width(input int stretch, input int stagger);
        int longest;
        longest = (stretch > stagger) ? stretch : stagger;
        return $clog2(longest + 1);
    endfunction

    function automatic int idx_width(input int n_out);
        return (n_out > 1) ? $clog2(n_out) : 1;
    endfunction

endpackage

// File: rtl/reset_sequencer_sync_chain.sv
// Generic reset synchroniser: asserts asynchronously with reset, releases
// SYNC_STAGES clock edges after reset goes high.
module reset_sync_chain
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic reset,
    output logic reset_sync
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("reset_sync_chain: SYNC_STAGES must be in 2..8");
    end

    (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] chain;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            chain <= '0;
        end else begin
            chain <= {chain[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign reset_sync = chain[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Staged reset generator: synchronises the board reset, holds all outputs for
// STRETCH cycles, then releases breset[0..N_OUT-1] every STAGGER cycles.
module reset_sequencer
    import reset_pkg::*;
#(
    parameter int SYNC_STAGES = 2,
    parameter int N_OUT       = 4,
    parameter int STRETCH     = 16,
    parameter int STAGGER     = 8,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             sw_reset_req,
    output logic [N_OUT-1:0] breset,
    output logic             ready,
    output logic [CNT_W-1:0] sw_reset_count
);

    localparam int CW = cnt_width(STRETCH, STAGGER);
    localparam int IW = idx_width(N_OUT);

    localparam logic [CW-1:0]    STRETCH_LAST = CW'(STRETCH - 1);
    localparam logic [CW-1:0]    STAGGER_LAST = CW'(STAGGER - 1);
    localparam logic [IW-1:0]    IDX_LAST     = IW'(N_OUT - 1);
    localparam logic [N_OUT-1:0] BIT0         = N_OUT'(1);

    if (N_OUT < N_OUT_MIN || N_OUT > N_OUT_MAX) begin : g_bad_n_out
        $error("reset_sequencer: N_OUT must be in 1..32");
    end
    if (STRETCH < STRETCH_MIN) begin : g_bad_stretch
        $error("reset_sequencer: STRETCH must be at least 1");
    end
    if (STAGGER < STAGGER_MIN) begin : g_bad_stagger
        $error("reset_sequencer: STAGGER must be at least 1");
    end
    if (CNT_W < CNT_W_MIN) begin : g_bad_cnt_w
        $error("reset_sequencer: CNT_W must be at least 1");
    end

    logic       rst_sync;
    logic       sw_accept;
    seq_state_t state;
    logic [CW-1:0] cnt;
    logic [IW-1:0] idx;

    reset_sync_chain #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync (
        .clk        (clk),
        .reset      (reset),
        .reset_sync (rst_sync)
    );

    // Requests only count once the synchronised reset has released.
    assign sw_accept = sw_reset_req & rst_sync;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            breset <= '0;
            ready  <= 1'b0;
        end else if (sw_accept) begin
            state  <= HOLD;
            cnt    <= '0;
            idx    <= '0;
            breset <= '0;
            ready  <= 1'b0;
        end else begin
            case (state)
                HOLD: begin
                    if (rst_sync) begin
                        if (cnt == STRETCH_LAST) begin
                            cnt    <= '0;
                            breset <= BIT0;
                            if (N_OUT == 1) begin
                                state <= RUN;
                            end else begin
                                idx   <= IW'(1);
                                state <= RELEASE;
                            end
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                RELEASE: begin
                    // idx names the next bit to release; bits are only ever OR-ed in.
                    if (cnt == STAGGER_LAST) begin
                        cnt    <= '0;
                        breset <= breset | (BIT0 << idx);
                        if (idx == IDX_LAST) begin
                            state <= RUN;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                RUN: begin
                    ready <= 1'b1;
                end
                default: begin
                    state <= HOLD;
                end
            endcase
        end
    end

    // Saturating event counter, cleared only by the board reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sw_reset_count <= '0;
        end else if (sw_accept && (sw_reset_count != '1)) begin
            sw_reset_count <= sw_reset_count + 1'b1;
        end
    end

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed bench for reset_sequencer: default configuration plus the
// N_OUT=1 / STRETCH=1 / STAGGER=1 / SYNC_STAGES=3 corner configuration.
module tb_reset_sequencer;

    logic       clk;
    logic       reset;
    logic       sw_reset_req;
    logic       sw_c;
    logic [3:0] breset;
    logic       ready;
    logic [7:0] sw_reset_count;
    logic [0:0] breset_c;
    logic       ready_c;
    logic [7:0] count_c;

    int n_cmp;
    int n_err;
    int e;

    reset_sequencer dut (
        .clk            (clk),
        .reset          (reset),
        .sw_reset_req   (sw_reset_req),
        .breset         (breset),
        .ready          (ready),
        .sw_reset_count (sw_reset_count)
    );

    reset_sequencer #(
        .SYNC_STAGES (3),
        .N_OUT       (1),
        .STRETCH     (1),
        .STAGGER     (1),
        .CNT_W       (8)
    ) dut_c (
        .clk            (clk),
        .reset          (reset),
        .sw_reset_req   (sw_c),
        .breset         (breset_c),
        .ready          (ready_c),
        .sw_reset_count (count_c)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s (edge %0d): got %0h, expected %0h", tag, e, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        e++;
        #1;
    endtask

    task automatic run_to(input int t);
        while (e < t) tick();
    endtask

    initial begin
        n_cmp        = 0;
        n_err        = 0;
        e            = 0;
        reset        = 1'b0;
        sw_reset_req = 1'b0;
        sw_c         = 1'b0;

        // Power-on: outputs held clear while reset is low
        repeat (3) @(posedge clk);
        #1;
        chk("por_breset", 32'(breset), 32'h0);
        chk("por_ready", 32'(ready), 32'h0);
        chk("por_count", 32'(sw_reset_count), 32'h0);
        reset = 1'b1;
        e = 0;

        run_to(3);  chk("c_breset_e3", 32'(breset_c), 32'h0);
        run_to(4);  chk("c_breset_e4", 32'(breset_c), 32'h1);
                    chk("c_ready_e4", 32'(ready_c), 32'h0);
        run_to(5);  chk("c_ready_e5", 32'(ready_c), 32'h1);

        run_to(17); chk("po_e17", 32'(breset), 32'h0);
        run_to(18); chk("po_e18", 32'(breset), 32'h1);
        run_to(25); chk("po_e25", 32'(breset), 32'h1);
        run_to(26); chk("po_e26", 32'(breset), 32'h3);
        run_to(34); chk("po_e34", 32'(breset), 32'h7);
        run_to(41); chk("po_e41", 32'(breset), 32'h7);
        run_to(42); chk("po_e42", 32'(breset), 32'hF);
                    chk("po_ready_e42", 32'(ready), 32'h0);
        run_to(43); chk("po_ready_e43", 32'(ready), 32'h1);
        run_to(50);

        // Mid-sequence asynchronous reset
        reset = 1'b0;
        tick();
        reset = 1'b1;
        e = 0;
        run_to(30); chk("mid_e30", 32'(breset), 32'h3);
        #3 reset = 1'b0;
        #1;
        chk("async_breset", 32'(breset), 32'h0);
        chk("async_ready", 32'(ready), 32'h0);
        run_to(40);
        reset = 1'b1;
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        chk("ignored_count", 32'(sw_reset_count), 32'h0);
        run_to(57); chk("rel_e57", 32'(breset), 32'h0);
        run_to(58); chk("rel_e58", 32'(breset), 32'h1);
        run_to(82); chk("rel_e82", 32'(breset), 32'hF);
        run_to(83); chk("rel_ready_e83", 32'(ready), 32'h1);

        // Software request from RUN
        run_to(99);
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        chk("sw1_breset", 32'(breset), 32'h0);
        chk("sw1_ready", 32'(ready), 32'h0);
        chk("sw1_count", 32'(sw_reset_count), 32'h1);
        run_to(115); chk("sw1_e115", 32'(breset), 32'h0);
        run_to(116); chk("sw1_e116", 32'(breset), 32'h1);
        run_to(139); chk("sw1_e139", 32'(breset), 32'h7);
        run_to(140); chk("sw1_e140", 32'(breset), 32'hF);
                     chk("sw1_ready_e140", 32'(ready), 32'h0);
        run_to(141); chk("sw1_ready_e141", 32'(ready), 32'h1);

        // Request during RELEASE restarts the sequence
        run_to(199);
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        chk("sw2_count", 32'(sw_reset_count), 32'h2);
        run_to(224); chk("sw3_pre", 32'(breset), 32'h3);
        sw_reset_req = 1'b1;
        tick();
        sw_reset_req = 1'b0;
        chk("sw3_breset", 32'(breset), 32'h0);
        chk("sw3_count", 32'(sw_reset_count), 32'h3);
        run_to(240); chk("sw3_e240", 32'(breset), 32'h0);
        run_to(241); chk("sw3_e241", 32'(breset), 32'h1);
        run_to(265); chk("sw3_e265", 32'(breset), 32'hF);
        run_to(266); chk("sw3_ready_e266", 32'(ready), 32'h1);

        // Request held high for 300 edges (300..599): count saturates
        run_to(299);
        sw_reset_req = 1'b1;
        while (e < 599) begin
            tick();
            if (e == 310 || e == 450 || e == 599) begin
                chk("hold_breset", 32'(breset), 32'h0);
                chk("hold_ready", 32'(ready), 32'h0);
            end
            if (e == 550) chk("hold_cnt_e550", 32'(sw_reset_count), 32'd254);
            if (e == 551) chk("hold_cnt_e551", 32'(sw_reset_count), 32'd255);
        end
        sw_reset_req = 1'b0;
        chk("sat_count", 32'(sw_reset_count), 32'd255);
        run_to(614); chk("hold_e614", 32'(breset), 32'h0);
        run_to(615); chk("hold_e615", 32'(breset), 32'h1);
        run_to(639); chk("hold_ready_e639", 32'(ready), 32'h0);
                     chk("hold_e639", 32'(breset), 32'hF);
        run_to(640); chk("hold_ready_e640", 32'(ready), 32'h1);
        chk("c_count_idle", 32'(count_c), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
